// File: rtl/morse_pkg.sv
// Shared definitions for the Morse decoder back end: letter width, blank
// segment pattern and the scroll state encoding.
package morse_pkg;

  localparam int LETTER_W = 5;
  localparam logic [6:0] BLANK_SEG = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } scroll_state_t;

endpackage

// File: rtl/display_rom.sv
// Letter-to-segment lookup (bit order g,f,e,d,c,b,a); codes 26-31 are blank.
module display_rom
  import morse_pkg::*;
(
  input  logic [LETTER_W-1:0] letter,
  output logic [6:0]          seg
);

  always_comb begin
    seg = BLANK_SEG;
    case (letter)
      5'd0:  seg = 7'h77;
      5'd1:  seg = 7'h7C;
      5'd2:  seg = 7'h39;
      5'd3:  seg = 7'h5E;
      5'd4:  seg = 7'h79;
      5'd5:  seg = 7'h71;
      5'd6:  seg = 7'h3D;
      5'd7:  seg = 7'h76;
      5'd8:  seg = 7'h06;
      5'd9:  seg = 7'h1E;
      5'd10: seg = 7'h75;
      5'd11: seg = 7'h38;
      5'd12: seg = 7'h37;
      5'd13: seg = 7'h54;
      5'd14: seg = 7'h5C;
      5'd15: seg = 7'h73;
      5'd16: seg = 7'h67;
      5'd17: seg = 7'h50;
      5'd18: seg = 7'h6D;
      5'd19: seg = 7'h78;
      5'd20: seg = 7'h3E;
      5'd21: seg = 7'h1C;
      5'd22: seg = 7'h2A;
      5'd23: seg = 7'h49;
      5'd24: seg = 7'h6E;
      5'd25: seg = 7'h5B;
      default: seg = BLANK_SEG;
    endcase
  end

endmodule

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the previous level and flags a 0->1 change
// in the same cycle the new level is seen.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic din_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_d <= 1'b0;
    else        din_d <= din;
  end

  assign pulse = din & ~din_d;

endmodule

// File: rtl/morse_msg_buffer.sv
// Logs decoded Morse letters and replays them on one 7-segment digit, each
// letter held for HOLD cycles followed by a one-cycle blank.
module morse_msg_buffer
  import morse_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int HOLD  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [LETTER_W-1:0]          letter_in,
  input  logic                         done_in,
  input  logic                         clear,
  input  logic                         scroll_en,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic [LETTER_W-1:0]          cur_letter,
  output logic                         cur_valid,
  output logic [6:0]                   display
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  // Next scroll index, wrapping against the current fill level.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] i,
                                             input logic [CW-1:0] n);
    logic [CW-1:0] inc;
    inc = CW'(i) + CW'(1);
    return (inc >= n) ? '0 : IW'(inc);
  endfunction

  logic [LETTER_W-1:0] mem [DEPTH];
  logic                capture;
  scroll_state_t       state;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_nxt;
  logic [HW-1:0]       hold_cnt;
  logic [6:0]          rom_seg;

  rise_detect u_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (done_in),
    .pulse (capture)
  );

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign idx_nxt = wrap_idx(idx, count);

  // Letter storage carries no reset; only the fill level qualifies it.
  always_ff @(posedge clk) begin
    if (capture && !clear && !full) mem[count[IW-1:0]] <= letter_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (capture) begin
      if (full) overflow <= 1'b1;
      else      count    <= count + CW'(1);
    end
  end

  // Scroll FSM; stop/clear overrides every other transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      hold_cnt   <= '0;
      cur_letter <= '0;
      cur_valid  <= 1'b0;
    end else if (clear || !scroll_en) begin
      state      <= IDLE;
      idx        <= '0;
      hold_cnt   <= '0;
      cur_letter <= '0;
      cur_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state      <= SHOW;
            idx        <= '0;
            hold_cnt   <= '0;
            cur_letter <= mem[0];
            cur_valid  <= 1'b1;
          end
        end
        SHOW: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= GAP;
            hold_cnt   <= '0;
            cur_letter <= '0;
            cur_valid  <= 1'b0;
          end else begin
            hold_cnt   <= hold_cnt + HW'(1);
            cur_letter <= mem[idx];
          end
        end
        GAP: begin
          state      <= SHOW;
          idx        <= idx_nxt;
          hold_cnt   <= '0;
          cur_letter <= mem[idx_nxt];
          cur_valid  <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          idx        <= '0;
          hold_cnt   <= '0;
          cur_letter <= '0;
          cur_valid  <= 1'b0;
        end
      endcase
    end
  end

  display_rom u_rom (
    .letter (cur_letter),
    .seg    (rom_seg)
  );

  assign display = cur_valid ? rom_seg : BLANK_SEG;

endmodule

// File: doc/morse_msg_buffer.md
# morse_msg_buffer

Message buffer and scrolling display stage downstream of the Morse `decoder`. Captures each decoded letter (0=a … 25=z) on the rising edge of the decoder's `done` level into a linear log of up to `DEPTH` entries. A scroll state machine replays the stored message on one 7-segment digit, showing each letter for `HOLD` cycles followed by a one-cycle blank, and wraps back to the first letter.

## Interface
Parameters:
- `DEPTH`, 16: number of letter slots; must be ≥2.
- `HOLD`, 4: cycles each letter is shown; must be ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `letter_in`  in  5  letter from the decoder; valid while `done_in` is high.
- `done_in`  in  1  decoder done level; a 0→1 transition marks a new letter.
- `clear`  in  1  synchronous flush of the log, overflow flag and scroll state.
- `scroll_en`  in  1  enables scrolling while high.
- `count`  out  $clog2(DEPTH+1)  number of stored letters.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky: a letter arrived while full.
- `cur_letter`  out  5  letter currently shown; 0 when not in SHOW.
- `cur_valid`  out  1  high only in SHOW.
- `display`  out  7  segments for `cur_letter` in SHOW; `BLANK_SEG` otherwise.

## Operation
- **Edge detect:** a registered `done_d` holds the previous `done_in`. A capture fires in a cycle when `done_in & ~done_d`. A level that stays high produces exactly one capture.
- **Capture, not full:** `mem[count] <= letter_in` and `count` increments.
- **Capture, full:** the letter is dropped and `overflow` is set. It stays set until `clear` or reset.
- **Letter range:** `letter_in` values 26–31 are stored unchanged. The display shows `BLANK_SEG` for them.
- **`clear`:** sets `count` to 0, `overflow` to 0 and the FSM to IDLE with `idx` 0. `done_d` still tracks `done_in`. If `clear` and a capture coincide, `clear` wins and the letter is discarded.
- **FSM states:** IDLE, SHOW, GAP. `idx` is the scroll index; `hold_cnt` counts from 0 to HOLD-1.
  - IDLE → SHOW when `scroll_en && count != 0`. On entry `idx` = 0 and `hold_cnt` = 0.
  - SHOW: `hold_cnt` increments each cycle. When `hold_cnt == HOLD-1`, go to GAP.
  - GAP (one cycle) → SHOW. `idx` becomes `idx+1`, or 0 when `idx+1 >= count` (using `count` as sampled in GAP). `hold_cnt` resets to 0.
  - Any state → IDLE on `!scroll_en` or `clear`, with `idx` set to 0. This takes priority over the transitions above.
- Letters captured during scrolling join the replay as soon as `idx` reaches them.
- **`display` path:** `display` comes combinationally from the registered `cur_letter`/`cur_valid` through `display_rom`. `cur_letter` is driven as `mem[idx]` in SHOW.

## Timing
- **Reset values:** `count` 0, `full` 0, `empty` 1, `overflow` 0, state IDLE, `idx` 0, `hold_cnt` 0, `done_d` 0, `cur_letter` 0, `cur_valid` 0, `display` `BLANK_SEG`. Memory contents are don't-care.
- **Reset mid-operation:** an asynchronous assertion of `rst_n` in any state forces these values immediately.
- **Capture latency:** if the edge is detected in cycle N, `count`, `full` and `overflow` update after the clock edge ending cycle N.
- **Scroll start:** with `scroll_en` high from cycle N and `count != 0`, SHOW of `idx` 0 is visible from cycle N+1.
- **Scroll period:** HOLD+1 cycles per letter. A full message takes `count*(HOLD+1)` cycles.
- **Scroll stop:** `scroll_en` falling in cycle N gives IDLE outputs from cycle N+1.

## Structure
- Shared package `morse_pkg`:
  - `BLANK_SEG` = 7'b0000000.
  - Letter width `LETTER_W` = 5.
  - Scroll state enum {IDLE, SHOW, GAP}.
- Instantiates the existing `display_rom` for letter→segment mapping.
- One new sub-module, `rise_detect` (registered rising-edge pulse with async active-low reset). The rest stays in the top module.

## Test plan
- Reset, then pulse `done_in` high for 3 cycles with `letter_in`=7 (h) → exactly one capture; `count`=1, `mem[0]`=7, `empty`=0.
- Capture h, i (7, 8), then `scroll_en`=1 with HOLD=4 → `cur_letter` 7 for 4 cycles, 1 blank cycle, 8 for 4 cycles, 1 blank, then 7 again; period 10 cycles.
- Capture 17 letters with DEPTH=16 → `full`=1 after the 16th; 17th dropped, `overflow`=1, `count` stays 16; `clear` → `count`=0, `overflow`=0, `empty`=1.
- `clear` in the same cycle as a `done_in` rising edge → `count` stays 0 and no letter is stored.
- While scrolling a 1-letter log, capture a second letter during SHOW → the next GAP advances to `idx`=1 and the new letter is shown.
- Assert `rst_n`=0 mid-SHOW → all outputs return to reset values immediately; after release, `count`=0 and the FSM is in IDLE.
